// File: rtl/score_digits_overlay.sv
// score_digits_overlay
//   Draws a NUM_DIGITS decimal number over an upstream VGA pixel stream.
//   The binary input is converted to BCD once per frame by a sequential
//   double-dabble FSM, so the displayed number never changes mid-frame.
//   Glyphs come from an external font ROM with one cycle of read latency.
//
// Ports
//   vga_clk, vga_rst      pixel clock, synchronous active-high reset
//   x_pos, y_pos          current pixel coordinate
//   value                 unsigned binary number to display
//   blink                 1 = digits blink with a BLINK_FRAMES half-period
//   bg_pixel              upstream pixel for (x_pos, y_pos)
//   font_addr, font_bit   font ROM address out, ROM data back one cycle later
//   busy                  BCD conversion in progress
//   pixel_data            composited pixel, three cycles after x/y/bg_pixel
//
// Optional build macro
//   SCORE_LZ_BLANK_EN     blank leading-zero digits (rightmost digit always drawn)
module score_digits_overlay #(
    parameter int          NUM_DIGITS   = 4,
    parameter int          VALUE_W      = 14,
    parameter int          SCALE        = 2,
    parameter int          GLYPH_W      = 32,
    parameter int          GLYPH_H      = 64,
    parameter int          ORIGIN_X     = 192,
    parameter int          ORIGIN_Y     = 176,
    parameter logic [11:0] FG_COLOR     = 12'h000,
    parameter int          BLINK_FRAMES = 30,
    parameter int          ADDR_W       = 15
) (
    input  logic               vga_clk,
    input  logic               vga_rst,
    input  logic [9:0]         x_pos,
    input  logic [9:0]         y_pos,
    input  logic [VALUE_W-1:0] value,
    input  logic               blink,
    input  logic [11:0]        bg_pixel,
    output logic [ADDR_W-1:0]  font_addr,
    input  logic               font_bit,
    output logic               busy,
    output logic [11:0]        pixel_data
);

    // Enough BCD nibbles to hold any VALUE_W-bit number (3 bits < 1 decade),
    // and never fewer than the displayed digits.
    localparam int BCD_DIGITS = (VALUE_W + 2) / 3;
    localparam int ACC_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
    localparam int ACC_W      = ACC_DIGITS * 4;
    localparam int SCALE_SH   = $clog2(SCALE);
    localparam int BOX_W      = NUM_DIGITS * GLYPH_W * SCALE;
    localparam int BOX_H      = GLYPH_H * SCALE;
    localparam int CNT_W      = $clog2(VALUE_W + 1);
    localparam int FCNT_W     = $clog2(BLINK_FRAMES + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t                  state_q, state_d;
    logic [VALUE_W-1:0]      bin_q, bin_d;
    logic [ACC_W-1:0]        acc_q, acc_d, accAdj;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_DIGITS*4-1:0] disp_q, disp_d;
    logic                    overflow;
    logic                    originSeen_q;
    logic                    frameStart;
    logic [FCNT_W-1:0]       frameCnt_q, frameCnt_d;
    logic                    hidden_q, hidden_d;

    int                      dxI, dyI, lxI, lyI, kI, colI, addrI;
    logic                    inBox, digitVisible, visible;
    logic [3:0]              digitSel;

    logic [ADDR_W-1:0]       font_addr_q;
    logic                    inBox1_q, vis1_q, inBox2_q, vis2_q;
    logic [11:0]             bg1_q, bg2_q, pixel_q;

    // Only the first cycle spent at (0,0) counts as a frame start.
    assign frameStart = (x_pos == 10'd0) && (y_pos == 10'd0) && !originSeen_q;
    assign busy       = (state_q != IDLE);
    assign font_addr  = font_addr_q;
    assign pixel_data = pixel_q;

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    always_comb begin
        accAdj = acc_q;
        for (int i = 0; i < ACC_DIGITS; i++) begin
            if (acc_q[i*4 +: 4] >= 4'd5) begin
                accAdj[i*4 +: 4] = acc_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    // Any nonzero nibble above the displayed digits means value >= 10^NUM_DIGITS.
    always_comb begin
        overflow = 1'b0;
        for (int i = NUM_DIGITS; i < ACC_DIGITS; i++) begin
            if (acc_q[i*4 +: 4] != 4'd0) begin
                overflow = 1'b1;
            end
        end
    end

    // Conversion FSM next state; the display register is written only in LOAD.
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        case (state_q)
            IDLE: begin
                if (frameStart) begin
                    bin_d   = value;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {acc_d, bin_d} = {accAdj[ACC_W-2:0], bin_q, 1'b0};
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(VALUE_W - 1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                disp_d  = overflow ? {NUM_DIGITS{4'd9}} : acc_q[NUM_DIGITS*4-1:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Blink phase: toggles each time the frame counter wraps; blink=0 pins it visible.
    always_comb begin
        frameCnt_d = frameCnt_q;
        hidden_d   = hidden_q;
        if (frameStart) begin
            if (frameCnt_q == FCNT_W'(BLINK_FRAMES - 1)) begin
                frameCnt_d = '0;
                hidden_d   = ~hidden_q;
            end else begin
                frameCnt_d = frameCnt_q + FCNT_W'(1);
            end
        end
        if (!blink) begin
            hidden_d = 1'b0;
        end
    end

`ifdef SCORE_LZ_BLANK_EN
    logic [NUM_DIGITS-1:0] lzMask;
    logic                  leadZero;

    // A digit is a leading zero when it and everything to its left is zero;
    // the rightmost digit is never blanked so zero still shows as "0".
    always_comb begin
        lzMask   = '0;
        leadZero = 1'b1;
        for (int i = 0; i < NUM_DIGITS - 1; i++) begin
            leadZero  = leadZero && (disp_q[(NUM_DIGITS-1-i)*4 +: 4] == 4'd0);
            lzMask[i] = leadZero;
        end
    end
`endif

    // Box geometry and ROM address; glyphs are stored mirrored, so the column is flipped.
    always_comb begin
        dxI          = int'(x_pos) - ORIGIN_X;
        dyI          = int'(y_pos) - ORIGIN_Y;
        inBox        = (dxI >= 0) && (dxI < BOX_W) && (dyI >= 0) && (dyI < BOX_H);
        lxI          = dxI >>> SCALE_SH;
        lyI          = dyI >>> SCALE_SH;
        kI           = lxI / GLYPH_W;
        colI         = lxI % GLYPH_W;
        digitSel     = 4'd0;
        digitVisible = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (kI == i) begin
                digitSel = disp_q[(NUM_DIGITS-1-i)*4 +: 4];
`ifdef SCORE_LZ_BLANK_EN
                digitVisible = !lzMask[i];
`endif
            end
        end
        addrI   = lyI * (10 * GLYPH_W) + int'(digitSel) * GLYPH_W + (GLYPH_W - 1 - colI);
        visible = digitVisible && !(blink && hidden_q);
    end

    // Conversion, frame and blink state.
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            state_q      <= IDLE;
            bin_q        <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            disp_q       <= '0;
            originSeen_q <= 1'b0;
            frameCnt_q   <= '0;
            hidden_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_q        <= bin_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            disp_q       <= disp_d;
            originSeen_q <= (x_pos == 10'd0) && (y_pos == 10'd0);
            frameCnt_q   <= frameCnt_d;
            hidden_q     <= hidden_d;
        end
    end

    // Three-stage pixel pipeline; S2 waits for the ROM bit of the S1 address.
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            font_addr_q <= '0;
            inBox1_q    <= 1'b0;
            vis1_q      <= 1'b0;
            bg1_q       <= '0;
            inBox2_q    <= 1'b0;
            vis2_q      <= 1'b0;
            bg2_q       <= '0;
            pixel_q     <= '0;
        end else begin
            if (inBox) begin
                font_addr_q <= ADDR_W'(addrI);
            end
            inBox1_q <= inBox;
            vis1_q   <= visible;
            bg1_q    <= bg_pixel;
            inBox2_q <= inBox1_q;
            vis2_q   <= vis1_q;
            bg2_q    <= bg1_q;
            pixel_q  <= (inBox2_q && vis2_q && font_bit) ? FG_COLOR : bg2_q;
        end
    end

endmodule

// File: tb/tb_score_digits_overlay.sv
// tb_score_digits_overlay
//   Self-checking bench for score_digits_overlay. Holds its own font ROM and a
//   decimal reference model of what each screen pixel should look like.
module tb_score_digits_overlay;

    localparam int          ND    = 4;
    localparam int          VW    = 14;
    localparam int          SC    = 2;
    localparam int          GW    = 32;
    localparam int          GH    = 64;
    localparam int          OX    = 192;
    localparam int          OY    = 176;
    localparam int          BF    = 2;
    localparam int          AW    = 15;
    localparam int          BOX_W = ND * GW * SC;
    localparam int          BOX_H = GH * SC;
    localparam logic [11:0] FG    = 12'h5A3;

    logic          vga_clk   = 1'b0;
    logic          vga_rst   = 1'b1;
    logic [9:0]    x_pos     = 10'd639;
    logic [9:0]    y_pos     = 10'd479;
    logic [VW-1:0] value     = '0;
    logic          blink     = 1'b0;
    logic [11:0]   bg_pixel  = 12'h111;
    logic [AW-1:0] font_addr;
    logic          font_bit  = 1'b0;
    logic          busy;
    logic [11:0]   pixel_data;

    bit rom [0:(1<<AW)-1];

    int checks       = 0;
    int errors       = 0;
    int shownValue   = 0;
    int frameNo      = 0;
    int modelAddr    = 0;
    bit modelHidden  = 1'b0;
    bit blinkRetired = 1'b0;

    typedef struct {
        int x;
        int y;
        bit inBox;
        int expAddr;
    } vec_t;

    score_digits_overlay #(
        .NUM_DIGITS(ND), .VALUE_W(VW), .SCALE(SC), .GLYPH_W(GW), .GLYPH_H(GH),
        .ORIGIN_X(OX), .ORIGIN_Y(OY), .FG_COLOR(FG), .BLINK_FRAMES(BF), .ADDR_W(AW)
    ) dut (
        .vga_clk(vga_clk), .vga_rst(vga_rst), .x_pos(x_pos), .y_pos(y_pos),
        .value(value), .blink(blink), .bg_pixel(bg_pixel), .font_addr(font_addr),
        .font_bit(font_bit), .busy(busy), .pixel_data(pixel_data)
    );

    always #5 vga_clk = ~vga_clk;

    // External font ROM with one cycle of read latency
    always @(posedge vga_clk) font_bit <= rom[font_addr];

    // ---------------- reference model ----------------
    function automatic int pow10(int n);
        int p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    function automatic int shownOf(int v);
        return (v >= pow10(ND)) ? pow10(ND) - 1 : v;
    endfunction

    function automatic int digitOf(int v, int k);
        return (shownOf(v) / pow10(ND - 1 - k)) % 10;
    endfunction

    function automatic bit leadZeroOf(int v, int k);
`ifdef SCORE_LZ_BLANK_EN
        return (k < ND - 1) && (shownOf(v) < pow10(ND - 1 - k));
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit inBoxM(int x, int y);
        return (x >= OX) && (x < OX + BOX_W) && (y >= OY) && (y < OY + BOX_H);
    endfunction

    function automatic int addrOf(int x, int y);
        int lx  = (x - OX) / SC;
        int ly  = (y - OY) / SC;
        int k   = lx / GW;
        int col = lx % GW;
        return ly * 10 * GW + digitOf(shownValue, k) * GW + (GW - 1 - col);
    endfunction

    function automatic logic [11:0] expPixel(int x, int y, logic [11:0] bg, bit blk);
        int k;
        if (!inBoxM(x, y)) return bg;
        if (blk && modelHidden) return bg;
        k = ((x - OX) / SC) / GW;
        if (leadZeroOf(shownValue, k)) return bg;
        return rom[addrOf(x, y)] ? FG : bg;
    endfunction

    function automatic logic [11:0] randBg();
        logic [11:0] b;
        b = 12'($urandom_range(1, 4095));
        if (b == FG) b = ~FG;
        return b;
    endfunction

    // ---------------- tasks ----------------
    task automatic stepClk();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic applyStimulus(input int x, input int y, input logic [11:0] bg, input bit blk);
        x_pos    = 10'(x);
        y_pos    = 10'(y);
        bg_pixel = bg;
        blink    = blk;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic park();
        applyStimulus(639, 479, 12'h111, blink);
    endtask

    task automatic frameStart(input string name, input int v);
        int busyCycles;
        busyCycles = 0;
        value = VW'(v);
        applyStimulus(0, 0, 12'h000, blink);
        stepClk();
        park();
        for (int i = 0; i < 40; i++) begin
            if (busy) busyCycles++;
            stepClk();
        end
        checkOutput({name, "_busy_cycles"}, busyCycles, VW + 1);
        shownValue = v;
        frameNo++;
        if (!blinkRetired) modelHidden = ((frameNo / BF) % 2) == 1;
    endtask

    task automatic checkPixelAt(input string name, input int x, input int y, input bit blk);
        logic [11:0] bg;
        logic [11:0] expPix;
        bg     = randBg();
        expPix = expPixel(x, y, bg, blk);
        if (inBoxM(x, y)) modelAddr = addrOf(x, y);
        applyStimulus(x, y, bg, blk);
        repeat (3) stepClk();
        checkOutput({name, "_pix"}, pixel_data, expPix);
        checkOutput({name, "_addr"}, font_addr, modelAddr);
    endtask

    // Pipelined random stream: each cycle a new pixel, compared three cycles later.
    task automatic streamRandom(input string name, input int n);
        logic [11:0] q[$];
        logic [11:0] expPix;
        logic [11:0] bg;
        int x, y;
        bit blk;
        for (int i = 0; i < n + 3; i++) begin
            if (i >= 3) begin
                expPix = q.pop_front();
                checkOutput({name, "_pix"}, pixel_data, expPix);
            end
            if (i >= 1) checkOutput({name, "_addr"}, font_addr, modelAddr);
            if (i < n) begin
                x   = $urandom_range(OX - 8, OX + BOX_W + 8);
                y   = $urandom_range(OY - 8, OY + BOX_H + 8);
                bg  = randBg();
                blk = 1'($urandom_range(0, 1));
            end else begin
                x   = 639;
                y   = 479;
                bg  = 12'h111;
                blk = 1'b0;
            end
            q.push_back(expPixel(x, y, bg, blk));
            if (inBoxM(x, y)) modelAddr = addrOf(x, y);
            applyStimulus(x, y, bg, blk);
            stepClk();
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        vec_t tbl[12];
        int   busyCycles;
        int   vals[6];
        logic [11:0] bg;

        tbl = '{
            '{192, 176, 1'b1, 63},
            '{191, 176, 1'b0, 63},
            '{194, 176, 1'b1, 62},
            '{448, 200, 1'b0, 62},
            '{320, 176, 1'b1, 127},
            '{200, 175, 1'b0, 127},
            '{255, 177, 1'b1, 32},
            '{200, 304, 1'b0, 32},
            '{256, 178, 1'b1, 415},
            '{447, 303, 1'b1, 20288},
            '{384, 240, 1'b1, 10399},
            '{639, 479, 1'b0, 10399}
        };

        for (int i = 0; i < (1 << AW); i++) rom[i] = 1'($urandom_range(0, 1));
        for (int d = 0; d < 10; d++) rom[d * GW + GW - 1] = 1'b1;

        // Reset held two cycles
        applyStimulus(300, 200, randBg(), 1'b1);
        value = VW'(1234);
        for (int i = 0; i < 2; i++) begin
            stepClk();
            checkOutput("rst_pixel", pixel_data, 0);
            checkOutput("rst_addr", font_addr, 0);
            checkOutput("rst_busy", busy, 0);
        end
        vga_rst = 1'b0;
        blink   = 1'b0;
        park();
        stepClk();
        checkPixelAt("rst_zero_digit", OX, OY, 1'b0);

        // Blink with BLINK_FRAMES=2: hidden on frames 2-3, 6-7, visible on 1, 4-5
        blink = 1'b1;
        for (int f = 1; f <= 6; f++) begin
            frameStart($sformatf("blink_f%0d", f), 1234);
            checkPixelAt($sformatf("blink_f%0d", f), OX, OY, 1'b1);
        end
        blink        = 1'b0;
        blinkRetired = 1'b1;
        modelHidden  = 1'b0;
        frameStart("blink_off", 1234);
        checkPixelAt("blink_off", OX, OY, 1'b0);

        // Address/pixel vector table for 1234
        for (int i = 0; i < 12; i++) begin
            bg = randBg();
            applyStimulus(tbl[i].x, tbl[i].y, bg, 1'b0);
            repeat (3) stepClk();
            checkOutput($sformatf("tbl%0d_addr", i), font_addr, tbl[i].expAddr);
            checkOutput($sformatf("tbl%0d_pix", i), pixel_data,
                        tbl[i].inBox ? (rom[tbl[i].expAddr] ? FG : bg) : bg);
        end
        modelAddr = 10399;

        // Saturation: 12000 displays as 9999
        frameStart("sat", 12000);
        for (int k = 0; k < ND; k++) begin
            applyStimulus(OX + k * GW * SC, OY, randBg(), 1'b0);
            repeat (2) stepClk();
            checkOutput($sformatf("sat_d%0d_addr", k), font_addr, 9 * GW + GW - 1);
        end
        modelAddr = 9 * GW + GW - 1;

        // Mid-frame value change is invisible until the next frame start
        frameStart("mid5", 5);
        value = VW'(7);
        repeat (20) stepClk();
        checkPixelAt("mid_still5", OX + 3 * GW * SC, OY, 1'b0);
        checkOutput("mid_still5_d", font_addr, 5 * GW + GW - 1);
        park();
        stepClk();
        frameStart("mid7", 7);
        checkPixelAt("mid_now7", OX + 3 * GW * SC, OY, 1'b0);
        checkOutput("mid_now7_d", font_addr, 7 * GW + GW - 1);

        // Frame start while busy is ignored
        park();
        stepClk();
        busyCycles = 0;
        for (int i = 0; i < 45; i++) begin
            if (i == 0) begin
                value = VW'(1234);
                applyStimulus(0, 0, 12'h000, 1'b0);
            end else if (i == 5) begin
                value = VW'(99);
                applyStimulus(0, 0, 12'h000, 1'b0);
            end else begin
                park();
            end
            stepClk();
            if (busy) busyCycles++;
        end
        checkOutput("ignore_busy_cycles", busyCycles, VW + 1);
        shownValue = 1234;
        checkPixelAt("ignore_disp", OX, OY, 1'b0);

        // Holding (0,0) starts only one conversion
        park();
        stepClk();
        busyCycles = 0;
        value = VW'(4321);
        applyStimulus(0, 0, 12'h000, 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (i == 20) value = VW'(1111);
            stepClk();
            if (busy) busyCycles++;
        end
        checkOutput("hold_busy_cycles", busyCycles, VW + 1);
        shownValue = 4321;
        checkPixelAt("hold_disp", OX, OY, 1'b0);

        // Reset mid-conversion aborts and leaves zeros displayed
        park();
        stepClk();
        value = VW'(8888);
        applyStimulus(0, 0, 12'h000, 1'b0);
        stepClk();
        park();
        repeat (4) stepClk();
        vga_rst = 1'b1;
        stepClk();
        vga_rst = 1'b0;
        checkOutput("rstmid_busy", busy, 0);
        checkOutput("rstmid_addr", font_addr, 0);
        shownValue = 0;
        modelAddr  = 0;
        frameNo    = 0;
        repeat (20) stepClk();
        checkOutput("rstmid_busy_later", busy, 0);
        checkPixelAt("rstmid_disp", OX + 3 * GW * SC, OY, 1'b0);

        // Leading-zero behaviour (blanked only with SCORE_LZ_BLANK_EN)
        park();
        stepClk();
        frameStart("lz42", 42);
        for (int k = 0; k < ND; k++) checkPixelAt($sformatf("lz42_d%0d", k), OX + k * GW * SC, OY, 1'b0);
        park();
        stepClk();
        frameStart("lz0", 0);
        for (int k = 0; k < ND; k++) checkPixelAt($sformatf("lz0_d%0d", k), OX + k * GW * SC, OY, 1'b0);

        // Randomized pixel streams over several values
        vals = '{0, 9999, 10000, 16383, int'($urandom_range(0, 16383)), int'($urandom_range(0, 999))};
        for (int r = 0; r < 6; r++) begin
            blink = 1'b0;
            park();
            stepClk();
            frameStart($sformatf("rnd%0d", r), vals[r]);
            streamRandom($sformatf("rnd%0d", r), 150);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
